// File: rtl/dds_wavegen.sv
// Direct digital synthesis waveform generator: phase accumulator feeding a
// two-stage pipeline that renders sine, square, triangle or sawtooth samples.
module dds_wavegen #(
  parameter int PHASE_W    = 24,
  parameter int OUT_W      = 10,
  parameter int LUT_ADDR_W = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [PHASE_W-1:0] ftw,
  input  logic               ftw_load,
  input  logic [PHASE_W-1:0] phase_off,
  input  logic [1:0]         mode,
  input  logic               phase_sync,
  output logic [OUT_W-1:0]   sample_out,
  output logic               sample_valid,
  output logic               wrap
);

  localparam int LUT_N = 2 ** LUT_ADDR_W;
  localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};
  localparam int LSB = (LUT_ADDR_W + 1 > OUT_W)
                     ? PHASE_W - 2 - LUT_ADDR_W
                     : PHASE_W - 1 - OUT_W;
  localparam int PW = PHASE_W - LSB;

  // Quarter-wave table, sampled at bin centres so no entry lands on 0 or peak twice
  logic [OUT_W-2:0] lut [LUT_N];

  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    localparam real AMP = real'(2 ** (OUT_W - 1) - 1);
    localparam real ANG = 1.5707963267948966 * (real'(k) + 0.5)
                          / real'(LUT_N);
    localparam int VAL = $rtoi(AMP * $sin(ANG) + 0.5);
    assign lut[k] = VAL[OUT_W-2:0];
  end

  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] ftw_active;
  logic [PHASE_W:0]   sum;
  logic               v_acc;

  assign sum = {1'b0, acc} + {1'b0, ftw_active};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      ftw_active <= '0;
      wrap       <= 1'b0;
      v_acc      <= 1'b0;
    end else begin
      if (ftw_load)
        ftw_active <= ftw;
      wrap  <= en & ~phase_sync & sum[PHASE_W];
      v_acc <= en;
      if (phase_sync)
        acc <= '0;
      else if (en)
        acc <= sum[PHASE_W-1:0];
    end
  end

  // Only the phase bits above LSB feed any field
  logic [PW-1:0] ph;

  assign ph = PW'((acc + phase_off) >> LSB);

  logic [1:0]            q_r;
  logic [LUT_ADDR_W-1:0] idx_r;
  logic [OUT_W-1:0]      top_r;
  logic [OUT_W-1:0]      tri_r;
  logic [1:0]            mode_r;
  logic                  v_s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r    <= '0;
      idx_r  <= '0;
      top_r  <= '0;
      tri_r  <= '0;
      mode_r <= '0;
      v_s1   <= 1'b0;
    end else begin
      q_r    <= ph[PW-1 -: 2];
      idx_r  <= ph[PW-3 -: LUT_ADDR_W];
      top_r  <= ph[PW-1 -: OUT_W];
      tri_r  <= ph[PW-2 -: OUT_W];
      mode_r <= mode;
      v_s1   <= v_acc;
    end
  end

  logic [LUT_ADDR_W-1:0] addr;
  logic [OUT_W-1:0]      lv;
  logic [OUT_W-1:0]      nxt;

  always_comb begin
    addr = q_r[0] ? ~idx_r : idx_r;
    lv   = {1'b0, lut[addr]};
    nxt  = MID;
    unique case (1'b1)
      mode_r == 2'd0: nxt = q_r[1] ? MID - lv : MID + lv;
      mode_r == 2'd1: nxt = q_r[1] ? '0 : '1;
      mode_r == 2'd2: nxt = q_r[1] ? ~tri_r : tri_r;
      default:        nxt = top_r;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_out   <= MID;
      sample_valid <= 1'b0;
    end else begin
      sample_out   <= nxt;
      sample_valid <= v_s1;
    end
  end

endmodule

// File: tb/tb_dds_wavegen.sv
// Scoreboard bench for dds_wavegen: a cycle model pushes expected outputs
// per edge, a monitor pops them; scenario tasks add targeted checks.
module tb_dds_wavegen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [23:0] ftw = '0;
  logic        ftw_load = 1'b0;
  logic [23:0] phase_off = '0;
  logic [1:0]  mode = '0;
  logic        phase_sync = 1'b0;
  logic [9:0]  sample_out;
  logic        sample_valid;
  logic        wrap;

  dds_wavegen #(
    .PHASE_W(24),
    .OUT_W(10),
    .LUT_ADDR_W(7)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .ftw(ftw),
    .ftw_load(ftw_load),
    .phase_off(phase_off),
    .mode(mode),
    .phase_sync(phase_sync),
    .sample_out(sample_out),
    .sample_valid(sample_valid),
    .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] s;
    logic       v;
    logic       w;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;
  bit mon_en = 1'b0;

  logic [23:0] m_acc;
  logic [23:0] m_ftw;
  logic        m_last_en;
  logic [9:0]  pend_s;
  logic        pend_v;
  int          lut_m [128];

  initial begin
    for (int k = 0; k < 128; k++)
      lut_m[k] = $rtoi(511.0 * $sin(3.14159265358979 * (k + 0.5) / 256.0) + 0.5);
  end

  function automatic logic [9:0] model_sample(logic [23:0] a_v,
                                              logic [1:0] md,
                                              logic [23:0] off);
    logic [23:0] pv;
    int p, quad, idx, a, t;
    pv = a_v + off;
    p = int'(pv);
    quad = p >> 22;
    idx = (p >> 15) & 127;
    t = (p >> 13) & 1023;
    if (md == 2'd0) begin
      a = (quad % 2 == 1) ? 127 - idx : idx;
      return (quad < 2) ? 10'(512 + lut_m[a]) : 10'(512 - lut_m[a]);
    end
    if (md == 2'd1)
      return (p < (1 << 23)) ? 10'd1023 : 10'd0;
    if (md == 2'd2)
      return (p < (1 << 23)) ? 10'(t) : 10'(1023 - t);
    return 10'(p >> 14);
  endfunction

  task automatic reset_model();
    m_acc = '0;
    m_ftw = '0;
    m_last_en = 1'b0;
    pend_s = model_sample(24'd0, 2'd0, 24'd0);
    pend_v = 1'b0;
    sb.delete();
  endtask

  task automatic tick();
    exp_t e;
    logic [24:0] s25;
    s25 = {1'b0, m_acc} + {1'b0, m_ftw};
    e.s = pend_s;
    e.v = pend_v;
    e.w = en && !phase_sync && s25[24];
    sb.push_back(e);
    pend_s = model_sample(m_acc, mode, phase_off);
    pend_v = m_last_en;
    @(posedge clk);
    if (phase_sync)
      m_acc = '0;
    else if (en)
      m_acc = s25[23:0];
    if (ftw_load)
      m_ftw = ftw;
    m_last_en = en;
    #2;
  endtask

  always @(posedge clk) begin
    if (mon_en) begin
      exp_t e;
      #1;
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL scoreboard_empty t=%0t", $time);
      end else begin
        e = sb.pop_front();
        if (sample_out !== e.s || sample_valid !== e.v || wrap !== e.w) begin
          n_errors++;
          $display("FAIL scoreboard t=%0t sample=%0d exp=%0d valid=%0b exp=%0b wrap=%0b exp=%0b",
                   $time, sample_out, e.s, sample_valid, e.v, wrap, e.w);
        end
      end
    end
  end

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (sample_out !== 10'd512 || sample_valid !== 1'b0 || wrap !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_async sample=%0d valid=%0b wrap=%0b exp 512/0/0",
               sample_out, sample_valid, wrap);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    mon_en = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_sine();
    int offs [3];
    int exps [3];
    int prev;
    offs = '{1 << 22, 1 << 23, 3 << 22};
    exps = '{1023, 509, 1};
    mode = 2'd0;
    phase_off = '0;
    ftw = '0;
    ftw_load = 1'b1;
    phase_sync = 1'b1;
    en = 1'b1;
    tick();
    ftw_load = 1'b0;
    phase_sync = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (sample_out !== 10'd515) begin
      n_errors++;
      $display("FAIL sine_phase0 got=%0d exp=515", sample_out);
    end
    prev = 515;
    for (int j = 0; j < 3; j++) begin
      phase_off = 24'(offs[j]);
      tick();
      n_checks++;
      if (sample_out !== 10'(prev)) begin
        n_errors++;
        $display("FAIL sine_hold off=%0d got=%0d exp=%0d", offs[j], sample_out, prev);
      end
      tick();
      n_checks++;
      if (sample_out !== 10'(exps[j])) begin
        n_errors++;
        $display("FAIL sine_offset off=%0d got=%0d exp=%0d", offs[j], sample_out, exps[j]);
      end
      prev = exps[j];
    end
    phase_off = '0;
  endtask

  task automatic test_sawtooth();
    int wraps, first_w, last_w, prev, bad, nvalid, first_v;
    mode = 2'd3;
    phase_off = '0;
    ftw = 24'(1 << 14);
    ftw_load = 1'b1;
    phase_sync = 1'b1;
    en = 1'b0;
    tick();
    ftw_load = 1'b0;
    phase_sync = 1'b0;
    tick();
    en = 1'b1;
    wraps = 0;
    first_w = -1;
    last_w = -1;
    prev = -1;
    bad = 0;
    nvalid = 0;
    first_v = -1;
    for (int i = 0; i < 2048; i++) begin
      tick();
      if (wrap === 1'b1) begin
        wraps++;
        if (first_w < 0)
          first_w = i;
        last_w = i;
      end
      if (sample_valid === 1'b1) begin
        if (prev < 0)
          first_v = int'(sample_out);
        else if (int'(sample_out) != (prev + 1) % 1024)
          bad++;
        prev = int'(sample_out);
        nvalid++;
      end
    end
    n_checks++;
    if (wraps != 2 || last_w - first_w != 1024) begin
      n_errors++;
      $display("FAIL saw_wrap count=%0d spacing=%0d exp 2/1024", wraps, last_w - first_w);
    end
    n_checks++;
    if (first_v != 1 || nvalid != 2046) begin
      n_errors++;
      $display("FAIL saw_valid first=%0d n=%0d exp 1/2046", first_v, nvalid);
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL saw_ramp steps_bad=%0d exp 0", bad);
    end
  endtask

  task automatic test_square_tri();
    int sq [32];
    int hi, per_bad, mx, mn;
    mode = 2'd1;
    phase_off = '0;
    ftw = 24'(1 << 20);
    ftw_load = 1'b1;
    phase_sync = 1'b1;
    en = 1'b0;
    tick();
    ftw_load = 1'b0;
    phase_sync = 1'b0;
    tick();
    en = 1'b1;
    repeat (4) tick();
    hi = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      sq[i] = int'(sample_out);
      if (sq[i] == 1023)
        hi++;
    end
    per_bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (sq[i] != sq[i + 16])
        per_bad++;
      if (i < 8 && sq[i] == sq[i + 8])
        per_bad++;
      if (sq[i] != 0 && sq[i] != 1023)
        per_bad++;
    end
    n_checks++;
    if (hi != 16 || per_bad != 0) begin
      n_errors++;
      $display("FAIL square_period high=%0d bad=%0d exp 16/0", hi, per_bad);
    end
    mode = 2'd2;
    repeat (2) tick();
    mx = -1;
    mn = 4096;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (int'(sample_out) > mx)
        mx = int'(sample_out);
      if (int'(sample_out) < mn)
        mn = int'(sample_out);
    end
    n_checks++;
    if (mx != 1023 || mn != 0) begin
      n_errors++;
      $display("FAIL tri_range max=%0d min=%0d exp 1023/0", mx, mn);
    end
  endtask

  task automatic test_ftw_load();
    mode = 2'd3;
    phase_off = '0;
    ftw = 24'(1 << 14);
    ftw_load = 1'b1;
    phase_sync = 1'b1;
    en = 1'b0;
    tick();
    ftw_load = 1'b0;
    phase_sync = 1'b0;
    tick();
    en = 1'b1;
    ftw = 24'(1 << 15);
    ftw_load = 1'b1;
    tick();
    ftw_load = 1'b0;
    tick();
    tick();
    n_checks++;
    if (sample_out !== 10'd1) begin
      n_errors++;
      $display("FAIL ftw_old_step got=%0d exp=1", sample_out);
    end
    tick();
    n_checks++;
    if (sample_out !== 10'd3) begin
      n_errors++;
      $display("FAIL ftw_new_step got=%0d exp=3", sample_out);
    end
    phase_sync = 1'b1;
    tick();
    phase_sync = 1'b0;
    en = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (sample_out !== 10'd0) begin
      n_errors++;
      $display("FAIL sync_saw got=%0d exp=0", sample_out);
    end
    mode = 2'd0;
    phase_sync = 1'b1;
    en = 1'b1;
    tick();
    phase_sync = 1'b0;
    en = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (sample_out !== 10'd515) begin
      n_errors++;
      $display("FAIL sync_sine got=%0d exp=515", sample_out);
    end
  endtask

  task automatic test_en_toggle();
    logic pat [6];
    logic [9:0] s [6];
    logic v [6];
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    mode = 2'd3;
    en = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 6; i++) begin
      en = pat[i];
      tick();
      s[i] = sample_out;
      v[i] = sample_valid;
    end
    n_checks++;
    if (v[2] !== 1'b1 || v[3] !== 1'b0 || v[4] !== 1'b1 || v[5] !== 1'b0) begin
      n_errors++;
      $display("FAIL en_valid_pattern got=%0b%0b%0b%0b exp=1010", v[2], v[3], v[4], v[5]);
    end
    n_checks++;
    if (s[3] !== s[2]) begin
      n_errors++;
      $display("FAIL en_hold got=%0d exp=%0d", s[3], s[2]);
    end
  endtask

  task automatic test_reset_mid();
    mode = 2'd3;
    en = 1'b1;
    repeat (5) tick();
    mon_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (sample_out !== 10'd512 || sample_valid !== 1'b0 || wrap !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid sample=%0d valid=%0b wrap=%0b exp 512/0/0",
               sample_out, sample_valid, wrap);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    mon_en = 1'b1;
    en = 1'b0;
    ftw = 24'(1 << 14);
    ftw_load = 1'b1;
    tick();
    ftw_load = 1'b0;
    en = 1'b1;
    repeat (6) tick();
    n_checks++;
    if (sample_out !== 10'd4 || sample_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_restart sample=%0d valid=%0b exp 4/1", sample_out, sample_valid);
    end
    en = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_sine();
    test_sawtooth();
    test_square_tri();
    test_ftw_load();
    test_en_toggle();
    test_reset_mid();
    mon_en = 1'b0;
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
